sdp_be_port_arbiter: RTL and testbench

//   Shares the write port of one simple-dual-port byte-enable BRAM between

---
 rtl/sdp_be_port_arbiter.sv | 85 ++++++++
 tb/tb_sdp_be_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_be_port_arbiter.sv
// Round-robin write-port arbiter and read sequencer for a simple-dual-port byte-enable BRAM.
// A read of the address being written this cycle is held off one cycle, so results never depend on the RAM collision mode.
module sdp_be_port_arbiter #(
    parameter int ABITS     = 10,
    parameter int BYTEWIDTH = 9,
    parameter int NBYTES    = 4,
    parameter int NREQ      = 2,
    localparam int DBITS    = NBYTES * BYTEWIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         wreq_valid,
    output logic [NREQ-1:0]         wreq_ready,
    input  logic [NREQ*ABITS-1:0]   wreq_addr,
    input  logic [NREQ*DBITS-1:0]   wreq_data,
    input  logic [NREQ*NBYTES-1:0]  wreq_be,
    input  logic                    rreq_valid,
    output logic                    rreq_ready,
    input  logic [ABITS-1:0]        rreq_addr,
    output logic                    rrsp_valid,
    output logic [DBITS-1:0]        rrsp_data,
    output logic                    we,
    output logic [ABITS-1:0]        wa,
    output logic [DBITS-1:0]        wd,
    output logic [NBYTES-1:0]       be,
    output logic [ABITS-1:0]        ra,
    input  logic [DBITS-1:0]        rd
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt_idx;
    logic [PW-1:0]     cand;
    logic              gnt_found;
    logic              grant;
    logic [ABITS-1:0]  sel_addr;
    logic [DBITS-1:0]  sel_data;
    logic [NBYTES-1:0] sel_be;
    logic              collide;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NREQ);
            if (!gnt_found && wreq_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign grant    = gnt_found && rst_n;
    assign sel_addr = wreq_addr[gnt_idx*ABITS +: ABITS];
    assign sel_data = wreq_data[gnt_idx*DBITS +: DBITS];
    assign sel_be   = wreq_be[gnt_idx*NBYTES +: NBYTES];

    assign wreq_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
    assign we         = grant && (|sel_be);
    assign wa         = sel_addr;
    assign wd         = sel_data;
    assign be         = grant ? sel_be : '0;

    // Only a real write (we=1) can hazard a read, so be==0 grants never stall.
    assign collide    = we && (wa == rreq_addr);
    assign rreq_ready = rst_n && !collide;
    assign ra         = rreq_addr;
    assign rrsp_data  = rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            rrsp_valid <= 1'b0;
        end else begin
            if (grant) begin
                rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            rrsp_valid <= rreq_valid && rreq_ready;
        end
    end

endmodule

// File: tb/tb_sdp_be_port_arbiter.sv
// Bench for sdp_be_port_arbiter: behavioural BRAM, shadow memory per byte lane and a round-robin reference.
// Directed steps for reset, fairness, byte enables, collisions and be==0, then randomized traffic with resets.
module tb_sdp_be_port_arbiter;

    localparam int ABITS = 10;
    localparam int BW    = 9;
    localparam int NB    = 4;
    localparam int NREQ  = 2;
    localparam int DBITS = NB * BW;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       wreq_valid;
    logic [NREQ-1:0]       wreq_ready;
    logic [NREQ*ABITS-1:0] wreq_addr;
    logic [NREQ*DBITS-1:0] wreq_data;
    logic [NREQ*NB-1:0]    wreq_be;
    logic                  rreq_valid;
    logic                  rreq_ready;
    logic [ABITS-1:0]      rreq_addr;
    logic                  rrsp_valid;
    logic [DBITS-1:0]      rrsp_data;
    logic                  we;
    logic [ABITS-1:0]      wa;
    logic [DBITS-1:0]      wd;
    logic [NB-1:0]         be;
    logic [ABITS-1:0]      ra;
    logic [DBITS-1:0]      rd;

    sdp_be_port_arbiter #(
        .ABITS(ABITS), .BYTEWIDTH(BW), .NBYTES(NB), .NREQ(NREQ)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr),
        .wreq_data(wreq_data), .wreq_be(wreq_be),
        .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
        .rrsp_valid(rrsp_valid), .rrsp_data(rrsp_data),
        .we(we), .wa(wa), .wd(wd), .be(be), .ra(ra), .rd(rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first behavioural SDP BRAM with registered read data.
    logic [DBITS-1:0] ram [0:(1<<ABITS)-1];
    always @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < NB; l++) begin
                if (be[l]) ram[wa][l*BW +: BW] <= wd[l*BW +: BW];
            end
        end
        rd <= ram[ra];
    end

    int checks = 0;
    int errors = 0;

    int               m_rr;
    bit               pend_v;
    logic [DBITS-1:0] pend_d;
    logic [DBITS-1:0] pend_m;
    logic [BW-1:0]    shadow [0:(1<<ABITS)-1][0:NB-1];
    bit               known  [0:(1<<ABITS)-1][0:NB-1];

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v,
                                 input logic [ABITS-1:0] a0, input logic [ABITS-1:0] a1,
                                 input logic [DBITS-1:0] d0, input logic [DBITS-1:0] d1,
                                 input logic [NB-1:0] b0, input logic [NB-1:0] b1,
                                 input logic rv, input logic [ABITS-1:0] raddr);
        wreq_valid = v;
        wreq_addr  = {a1, a0};
        wreq_data  = {d1, d0};
        wreq_be    = {b1, b0};
        rreq_valid = rv;
        rreq_addr  = raddr;
    endtask

    // One clock: compare against the reference at the falling edge, then advance the model at the rising edge.
    task automatic checkOutput();
        int               gi;
        logic [ABITS-1:0] ga;
        logic [DBITS-1:0] gd;
        logic [NB-1:0]    gb;
        bit               exp_we;
        bit               exp_rr;
        bit               nv;
        logic [DBITS-1:0] nd;
        logic [DBITS-1:0] nm;
        @(negedge clk);
        if (!rst_n) begin
            checkVal("rst_wreq_ready", wreq_ready, 0);
            checkVal("rst_rreq_ready", rreq_ready, 0);
            checkVal("rst_we", we, 0);
            checkVal("rst_be", be, 0);
            checkVal("rst_rrsp_valid", rrsp_valid, 0);
            m_rr   = 0;
            pend_v = 0;
            @(posedge clk);
            #1;
            return;
        end
        gi = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_rr + k) % NREQ;
            if (gi < 0 && wreq_valid[idx]) gi = idx;
        end
        ga = '0; gd = '0; gb = '0;
        if (gi >= 0) begin
            ga = wreq_addr[gi*ABITS +: ABITS];
            gd = wreq_data[gi*DBITS +: DBITS];
            gb = wreq_be[gi*NB +: NB];
        end
        exp_we = (gi >= 0) && (gb != 0);
        exp_rr = !(exp_we && ga == rreq_addr);
        checkVal("wreq_ready", wreq_ready, (gi >= 0) ? (64'd1 << gi) : 64'd0);
        checkVal("we", we, exp_we);
        checkVal("be", be, gb);
        if (gi >= 0) begin
            checkVal("wa", wa, ga);
            checkVal("wd", wd, gd);
        end
        checkVal("ra", ra, rreq_addr);
        checkVal("rreq_ready", rreq_ready, exp_rr);
        checkVal("rrsp_valid", rrsp_valid, pend_v);
        if (pend_v && pend_m != 0) checkVal("rrsp_data", rrsp_data & pend_m, pend_d & pend_m);
        nv = rreq_valid && exp_rr;
        nd = '0; nm = '0;
        for (int l = 0; l < NB; l++) begin
            if (known[rreq_addr][l]) begin
                nm[l*BW +: BW] = '1;
                nd[l*BW +: BW] = shadow[rreq_addr][l];
            end
        end
        @(posedge clk);
        if (gi >= 0) m_rr = (gi + 1) % NREQ;
        if (exp_we) begin
            for (int l = 0; l < NB; l++) begin
                if (gb[l]) begin
                    shadow[ga][l] = gd[l*BW +: BW];
                    known[ga][l]  = 1'b1;
                end
            end
        end
        pend_v = nv;
        pend_d = nd;
        pend_m = nm;
        #1;
    endtask

    localparam logic [DBITS-1:0] ALL1FF = {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
    localparam logic [DBITS-1:0] LANE2  = {9'h000, 9'h0AA, 9'h000, 9'h000};
    localparam logic [DBITS-1:0] MERGED = {9'h1FF, 9'h0AA, 9'h1FF, 9'h1FF};
    localparam logic [DBITS-1:0] NEW7   = {9'h123, 9'h045, 9'h167, 9'h089};

    initial begin
        logic [NREQ-1:0] rr_exp [0:3];
        logic [NREQ-1:0] rv_v;
        logic [NB-1:0]   rb0, rb1;
        m_rr   = 0;
        pend_v = 0;
        pend_d = '0;
        pend_m = '0;
        for (int a = 0; a < (1 << ABITS); a++)
            for (int l = 0; l < NB; l++) known[a][l] = 1'b0;

        $display("[TB] reset with all requests valid");
        rst_n = 1'b0;
        applyStimulus(2'b11, 10'd1, 10'd2, 36'h1, 36'h2, 4'hF, 4'hF, 1'b1, 10'd3);
        checkOutput();
        checkOutput();

        $display("[TB] release and round-robin");
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 10'h10 + 10'(i), 10'h20 + 10'(i),
                          36'(32'hA000 + i), 36'(32'hB000 + i), 4'hF, 4'hF, 1'b1, 10'd3);
            #1;
            checkVal("rr_grant", wreq_ready, rr_exp[i]);
            checkOutput();
        end

        $display("[TB] byte-enable merge");
        applyStimulus(2'b01, 10'd5, 10'd0, ALL1FF, 36'h0, 4'b1111, 4'b0000, 1'b0, 10'd0);
        checkOutput();
        applyStimulus(2'b10, 10'd0, 10'd5, 36'h0, LANE2, 4'b0000, 4'b0100, 1'b0, 10'd0);
        checkOutput();
        applyStimulus(2'b00, 10'd0, 10'd0, 36'h0, 36'h0, 4'h0, 4'h0, 1'b1, 10'd5);
        checkOutput();
        checkVal("be_merge_valid", rrsp_valid, 1);
        checkVal("be_merge_data", rrsp_data, MERGED);

        $display("[TB] read/write collision");
        applyStimulus(2'b01, 10'd7, 10'd0, NEW7, 36'h0, 4'hF, 4'h0, 1'b1, 10'd7);
        #1;
        checkVal("collide_stall", rreq_ready, 0);
        checkOutput();
        applyStimulus(2'b00, 10'd0, 10'd0, 36'h0, 36'h0, 4'h0, 4'h0, 1'b1, 10'd7);
        #1;
        checkVal("collide_retry", rreq_ready, 1);
        checkOutput();
        checkVal("collide_data", rrsp_data, NEW7);

        $display("[TB] zero byte-enable request");
        applyStimulus(2'b01, 10'd9, 10'd0, 36'h5, 36'h0, 4'hF, 4'h0, 1'b0, 10'd0);
        checkOutput();
        applyStimulus(2'b10, 10'd0, 10'd9, 36'h0, 36'h7, 4'h0, 4'h0, 1'b1, 10'd9);
        #1;
        checkVal("be0_ready", wreq_ready, 2'b10);
        checkVal("be0_we", we, 0);
        checkVal("be0_no_stall", rreq_ready, 1);
        checkOutput();
        applyStimulus(2'b11, 10'd11, 10'd12, 36'h11, 36'h12, 4'hF, 4'hF, 1'b0, 10'd0);
        #1;
        checkVal("be0_ptr_advance", wreq_ready, 2'b01);
        checkOutput();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            rv_v = NREQ'($urandom);
            rb0  = ($urandom_range(0, 3) == 0) ? 4'h0 : NB'($urandom);
            rb1  = ($urandom_range(0, 3) == 0) ? 4'h0 : NB'($urandom);
            applyStimulus(rv_v, ABITS'($urandom_range(0, 15)), ABITS'($urandom_range(0, 15)),
                          DBITS'({$urandom, $urandom}), DBITS'({$urandom, $urandom}),
                          rb0, rb1, 1'($urandom), ABITS'($urandom_range(0, 15)));
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                checkOutput();
                rst_n = 1'b1;
            end else begin
                checkOutput();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
